rv_cluster_mem_arb: RTL and testbench
=====================================

# rv_cluster_mem_arb

Shared-memory-port arbiter for a multi-hart RISC-V cluster. Sits between N_HARTS core data-side ports and the single memory-controller port, granting one hart at a time in round-robin order. It latches the granted request, tracks the controller's busy handshake to completion and returns read data plus a done pulse to the owning hart. Optional per-hart lock keeps ownership across back-to-back transactions for atomic read-modify-write sequences.

## Interface
- N_HARTS, 2: number of hart channels, 1..8
- ACK_TIMEOUT, 4: cycles to wait for w_busy rise before the access is treated as zero-latency complete, 1..15
- CLK  in  1  clock
- RST_X  in  1  reset; one clock, reset is synchronous and active-low
- i_req  in  N_HARTS  per-hart request level, held until o_done
- i_lock  in  N_HARTS  per-hart hold-ownership request, sampled in RESP
- i_addr  in  32*N_HARTS  per-hart address, hart h at [32h+31:32h]
- i_wdata  in  32*N_HARTS  per-hart write data
- i_we  in  N_HARTS  per-hart write enable
- i_ctrl  in  3*N_HARTS  per-hart size/sign control
- o_gnt  out  N_HARTS  one-hot current owner, 0 when idle
- o_done  out  N_HARTS  one-cycle completion pulse to owner
- o_stall  out  N_HARTS  i_req[h] & ~o_gnt[h]
- o_rdata  out  128  read data captured at completion, broadcast
- w_mem_req  out  1  one-cycle issue pulse to controller
- w_data_addr  out  32  latched address
- w_data_wdata  out  32  latched write data
- w_data_we  out  1  latched write enable, valid while w_mem_req
- w_data_ctrl  out  3  latched control
- w_busy  in  1  controller busy
- w_data_data  in  128  controller read data

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.
- IDLE: if any i_req, select first requester at or after pointer ptr (wrapping N_HARTS-1 -> 0); latch addr/wdata/we/ctrl, set o_gnt -> ISSUE. No requests: stay.
- ISSUE: w_mem_req=1 for exactly one cycle; clear timeout counter -> WAIT_ACK.
- WAIT_ACK: w_busy=1 -> WAIT_DONE; else counter increments; counter == ACK_TIMEOUT-1 without w_busy -> RESP, capturing w_data_data that cycle.
- WAIT_DONE: w_busy=0 -> RESP, capturing w_data_data that cycle.
- RESP: o_done[owner]=1 one cycle. If i_lock[owner] & i_req[owner]: relatch owner's request -> ISSUE, ptr unchanged, o_gnt held. Else ptr = owner+1 (wrap), o_gnt=0 -> IDLE.
- Owner dropping i_req mid-transaction: ignored; transaction completes, o_done still pulses.
- Request inputs changing after grant: no effect (latched).
- Simultaneous requests: lowest index at or after ptr wins; every requester granted within N_HARTS transactions unless a lock is held.
- Lock starvation is bounded by the hart, not the arbiter.
- N_HARTS=1: ptr fixed 0, behaviour otherwise identical.

## Timing
- Reset (RST_X=0 at edge): state IDLE, ptr 0, o_gnt 0, o_done 0, w_mem_req 0, o_rdata 0, latched addr/wdata/ctrl 0, we 0, timeout counter 0. Mid-transaction reset abandons the access without o_done.
- Request at IDLE edge t -> o_gnt at t+1, w_mem_req at t+1 (ISSUE), WAIT_ACK from t+2.
- Controller with busy high k≥1 cycles starting t+2: RESP at t+3+k, o_done in that cycle, o_rdata valid from t+4+k.
- Timeout path: o_done at t+2+ACK_TIMEOUT.
- Minimum unlocked turnaround: 5 cycles; locked back-to-back omits IDLE.
- o_stall combinational from i_req and registered o_gnt.

## Structure
- Shared package rv_cluster_pkg: state enum, XLEN=32, LINE_W=128, CTRL_W=3, MAX_HARTS=8.
- Sub-module rv_rr_pick: combinational round-robin picker (req vector, ptr -> one-hot grant, index, any).
- FSM, latches, timeout counter in top.

## Test plan
- Single hart 0 read, busy high 3 cycles, w_data_data=0x…DEADBEEF -> w_mem_req once, o_done[0] 6 cycles after request, o_rdata=0x…DEADBEEF.
- N_HARTS=4, all requesting continuously, ptr=0 -> grant order 0,1,2,3,0; o_stall high for non-owners.
- Busy never rises, ACK_TIMEOUT=4 -> o_done 6 cycles after request, next hart granted.
- Hart 2 with i_lock=1 three transactions -> o_gnt stays 0b0100, no IDLE between; then lock drops -> hart 3 granted.
- RST_X low during WAIT_DONE -> next cycle IDLE, all outputs 0, no o_done; fresh request from hart 1 -> granted (ptr 0 scan).
- Owner drops i_req in WAIT_ACK; addr changed -> w_data_addr unchanged, o_done still pulses.

Source files
------------

// File: rtl/rv_cluster_pkg.sv
// rv_cluster_pkg: shared types and widths for the cluster memory arbiter.
// Exports the arbiter state enum, the latched request bundle and widths.
package rv_cluster_pkg;

  localparam int XLEN      = 32;
  localparam int LINE_W    = 128;
  localparam int CTRL_W    = 3;
  localparam int MAX_HARTS = 8;
  localparam int TMO_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic              we;
    logic [CTRL_W-1:0] ctrl;
  } mem_req_t;

  // Width of a hart index; a single hart still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv_cluster_mem_arb_pick.sv
// rv_rr_pick: combinational round-robin picker.
// Ports: req vector, ptr start index -> one-hot gnt, binary idx, any.
module rv_rr_pick
  import rv_cluster_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/rv_cluster_mem_arb.sv
// rv_cluster_mem_arb: round-robin arbiter from N hart ports to one mem port.
// Ports: CLK/RST_X, per-hart i_* requests, o_gnt/o_done/o_stall/o_rdata, w_* controller side.
module rv_cluster_mem_arb
  import rv_cluster_pkg::*;
#(
  parameter int N_HARTS     = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                      CLK,
  input  logic                      RST_X,
  input  logic [N_HARTS-1:0]        i_req,
  input  logic [N_HARTS-1:0]        i_lock,
  input  logic [XLEN*N_HARTS-1:0]   i_addr,
  input  logic [XLEN*N_HARTS-1:0]   i_wdata,
  input  logic [N_HARTS-1:0]        i_we,
  input  logic [CTRL_W*N_HARTS-1:0] i_ctrl,
  output logic [N_HARTS-1:0]        o_gnt,
  output logic [N_HARTS-1:0]        o_done,
  output logic [N_HARTS-1:0]        o_stall,
  output logic [LINE_W-1:0]         o_rdata,
  output logic                      w_mem_req,
  output logic [XLEN-1:0]           w_data_addr,
  output logic [XLEN-1:0]           w_data_wdata,
  output logic                      w_data_we,
  output logic [CTRL_W-1:0]         w_data_ctrl,
  input  logic                      w_busy,
  input  logic [LINE_W-1:0]         w_data_data
);

  localparam int PW = idx_w(N_HARTS);
  localparam logic [PW-1:0] LAST =
    PW'(N_HARTS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(ACK_TIMEOUT - 1);

  arb_state_e         state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      own;
  logic [PW-1:0]      nxt_ptr;
  logic [PW-1:0]      src;
  logic [PW-1:0]      pick_idx;
  logic [N_HARTS-1:0] pick_gnt;
  logic               pick_any;
  logic [TMO_W-1:0]   tmo;
  mem_req_t           lat_q;
  mem_req_t           sel;

  rv_rr_pick #(
    .N  (N_HARTS),
    .PW (PW)
  ) u_pick (
    .req (i_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // One mux serves both the first grant and the locked relatch.
  assign src = (state == RESP) ? own : pick_idx;

  always_comb begin
    sel.addr  = i_addr[XLEN*src +: XLEN];
    sel.wdata = i_wdata[XLEN*src +: XLEN];
    sel.we    = i_we[src];
    sel.ctrl  = i_ctrl[CTRL_W*src +: CTRL_W];
  end

  assign nxt_ptr = (own == LAST) ? '0 : own + 1'b1;

  assign o_stall      = i_req & ~o_gnt;
  assign w_data_addr  = lat_q.addr;
  assign w_data_wdata = lat_q.wdata;
  assign w_data_we    = lat_q.we;
  assign w_data_ctrl  = lat_q.ctrl;

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state     <= IDLE;
      ptr       <= '0;
      own       <= '0;
      tmo       <= '0;
      lat_q     <= '0;
      o_gnt     <= '0;
      o_done    <= '0;
      w_mem_req <= 1'b0;
      o_rdata   <= '0;
    end else begin
      w_mem_req <= 1'b0;
      o_done    <= '0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            lat_q     <= sel;
            own       <= pick_idx;
            o_gnt     <= pick_gnt;
            w_mem_req <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          tmo   <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (w_busy) begin
            state <= WAIT_DONE;
          end else if (tmo == TMO_LAST) begin
            // No busy seen: treat as zero-latency.
            o_rdata <= w_data_data;
            o_done  <= o_gnt;
            state   <= RESP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!w_busy) begin
            o_rdata <= w_data_data;
            o_done  <= o_gnt;
            state   <= RESP;
          end
        end
        RESP: begin
          if (i_lock[own] & i_req[own]) begin
            lat_q     <= sel;
            w_mem_req <= 1'b1;
            state     <= ISSUE;
          end else begin
            ptr   <= nxt_ptr;
            o_gnt <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_cluster_mem_arb.sv
// tb_rv_cluster_mem_arb: self-checking bench for rv_cluster_mem_arb (4 harts).
// Vector table, hand-written corner sequences and a randomized model run.
module tb_rv_cluster_mem_arb;

  localparam int N  = 4;
  localparam int AT = 4;

  logic         CLK = 1'b0;
  logic         RST_X = 1'b0;
  logic [3:0]   i_req = '0;
  logic [3:0]   i_lock = '0;
  logic [127:0] i_addr = '0;
  logic [127:0] i_wdata = '0;
  logic [3:0]   i_we = '0;
  logic [11:0]  i_ctrl = '0;
  logic [3:0]   o_gnt, o_done, o_stall;
  logic [127:0] o_rdata;
  logic         w_mem_req;
  logic [31:0]  w_data_addr, w_data_wdata;
  logic         w_data_we;
  logic [2:0]   w_data_ctrl;
  logic         w_busy = 1'b0;
  logic [127:0] w_data_data = '0;

  rv_cluster_mem_arb #(
    .N_HARTS     (N),
    .ACK_TIMEOUT (AT)
  ) dut (
    .CLK          (CLK),
    .RST_X        (RST_X),
    .i_req        (i_req),
    .i_lock       (i_lock),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_we         (i_we),
    .i_ctrl       (i_ctrl),
    .o_gnt        (o_gnt),
    .o_done       (o_done),
    .o_stall      (o_stall),
    .o_rdata      (o_rdata),
    .w_mem_req    (w_mem_req),
    .w_data_addr  (w_data_addr),
    .w_data_wdata (w_data_wdata),
    .w_data_we    (w_data_we),
    .w_data_ctrl  (w_data_ctrl),
    .w_busy       (w_busy),
    .w_data_data  (w_data_data)
  );

  always #5 CLK = ~CLK;

  // Controller model: busy high for cur_lat cycles after each issue.
  int           cur_lat = 0;
  logic [127:0] cur_data = '0;
  int           busy_left = 0;

  always @(posedge CLK) begin
    logic issued, rst_now;
    issued  = w_mem_req;
    rst_now = !RST_X;
    #1;
    if (rst_now) begin
      busy_left = 0;
      w_busy    = 1'b0;
    end else if (issued) begin
      busy_left   = cur_lat;
      w_busy      = (cur_lat > 0);
      w_data_data = cur_data;
    end else if (busy_left > 0) begin
      busy_left--;
      w_busy = (busy_left > 0);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h want %h",
               name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  typedef struct {
    int           h;
    int           lat;
    logic         we;
    logic [2:0]   ctrl;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] rdata;
    bit           drop;
    int           dly;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int         n;
    int         iss;
    logic [3:0] oh;
    oh       = 4'b0001 << v.h;
    cur_lat  = v.lat;
    cur_data = v.rdata;
    i_addr[32*v.h +: 32]  = v.addr;
    i_wdata[32*v.h +: 32] = v.wdata;
    i_we[v.h]             = v.we;
    i_ctrl[3*v.h +: 3]    = v.ctrl;
    i_req[v.h]            = 1'b1;
    n   = 0;
    iss = 0;
    do begin
      tick();
      n++;
      if (w_mem_req) iss++;
      if (n == 1) begin
        chk("vec_gnt", o_gnt, oh);
        chk("vec_issue", w_mem_req, 1'b1);
        chk("vec_addr", w_data_addr, v.addr);
        chk("vec_wdata", w_data_wdata, v.wdata);
        chk("vec_we", w_data_we, v.we);
        chk("vec_ctrl", w_data_ctrl, v.ctrl);
      end
      if (v.drop && n == 2) begin
        i_req[v.h]            = 1'b0;
        i_addr[32*v.h +: 32]  = ~v.addr;
        i_wdata[32*v.h +: 32] = ~v.wdata;
      end
    end while (o_done == '0 && n < 30);
    chk("vec_delay", n, v.dly);
    chk("vec_done", o_done, oh);
    chk("vec_addr_held", w_data_addr, v.addr);
    chk("vec_issues", iss, 1);
    i_req[v.h] = 1'b0;
    tick();
    chk("vec_rdata", o_rdata, v.rdata);
    chk("vec_gnt_idle", o_gnt, 4'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (o_done == '0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_done", (o_done != '0), 1'b1);
    tick();
  endtask

  task automatic new_fields(input int h);
    i_addr[32*h +: 32]  = $urandom;
    i_wdata[32*h +: 32] = $urandom;
    i_we[h]             = 1'($urandom_range(0, 1));
    i_ctrl[3*h +: 3]    = 3'($urandom_range(0, 7));
  endtask

  function automatic int rr_pick(input logic [3:0] r,
                                 input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Reference model state for the randomized run.
  int           owner, issue_at, done_at;
  int           idle_from, mptr, rd_at, lat;
  logic [31:0]  e_addr, e_wdata;
  logic         e_we;
  logic [2:0]   e_ctrl;
  logic [127:0] e_rdata, rd_exp;

  task automatic start_txn(input int h, input int at);
    issue_at = at;
    e_addr   = i_addr[32*h +: 32];
    e_wdata  = i_wdata[32*h +: 32];
    e_we     = i_we[h];
    e_ctrl   = i_ctrl[3*h +: 3];
    lat      = $urandom_range(0, 5);
    cur_lat  = lat;
    cur_data = {$urandom, $urandom, $urandom, $urandom};
    e_rdata  = cur_data;
    done_at  = at + ((lat > 0) ? lat + 2 : AT + 1);
  endtask

  vec_t       vecs[5];
  vec_t       rv;
  logic [3:0] got[5];
  logic [3:0] exp_ord[5];
  logic [3:0] nxt, exp_g;
  int         ng, n, d2, iss2, bad, started, skip, dn;

  initial begin
    vecs[0] = '{0, 3, 1'b0, 3'd2, 32'h1000_0040,
                32'h0, 128'h0123_4567_89AB_CDEF_0000_1111_DEAD_BEEF,
                1'b0, 6};
    vecs[1] = '{1, 0, 1'b0, 3'd4, 32'h2000_0004,
                32'h0, 128'h77, 1'b0, 2 + AT};
    vecs[2] = '{2, 1, 1'b1, 3'd1, 32'h3000_0008,
                32'hCAFE_F00D, 128'h55AA, 1'b0, 4};
    vecs[3] = '{0, 2, 1'b1, 3'd7, 32'h4000_000C,
                32'h1234_5678, 128'h99, 1'b1, 5};
    vecs[4] = '{3, 5, 1'b0, 3'd0, 32'h5000_0010,
                32'h0, 128'hF00, 1'b0, 8};
    exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_gnt", o_gnt, 4'b0);
    chk("rst_done", o_done, 4'b0);
    chk("rst_memreq", w_mem_req, 1'b0);
    chk("rst_rdata", o_rdata, 128'h0);
    chk("rst_addr", w_data_addr, 32'h0);
    chk("rst_wdata", w_data_wdata, 32'h0);
    chk("rst_we", w_data_we, 1'b0);
    chk("rst_ctrl", w_data_ctrl, 3'h0);
    chk("rst_stall", o_stall, 4'b0);
    RST_X = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // All harts requesting continuously from ptr 0
    i_req    = 4'hF;
    cur_lat  = 1;
    cur_data = 128'h5;
    ng = 0;
    n  = 0;
    for (int i = 0; i < 5; i++) got[i] = '0;
    while (ng < 5 && n < 80) begin
      tick();
      n++;
      if (w_mem_req) begin
        got[ng] = o_gnt;
        chk("rr_stall", o_stall, ~o_gnt & 4'hF);
        ng++;
      end
    end
    i_req = '0;
    for (int i = 0; i < 5; i++)
      chk("rr_order", got[i], exp_ord[i]);
    drain();

    // Hart 2 holds a lock for three transactions
    i_req   = 4'b1100;
    i_lock  = 4'b0100;
    cur_lat = 1;
    d2 = 0; iss2 = 0; bad = 0;
    started = 0; n = 0; nxt = '0;
    while (nxt == '0 && n < 80) begin
      tick();
      n++;
      if (w_mem_req) begin
        if (d2 < 3) iss2++;
        else nxt = o_gnt;
      end
      if (o_gnt != '0) started = 1;
      if (started != 0 && d2 < 3 && o_gnt != 4'b0100)
        bad++;
      if (o_done[2]) begin
        d2++;
        if (d2 == 3) begin
          i_lock[2] = 1'b0;
          i_req[2]  = 1'b0;
        end
      end
    end
    chk("lock_hold", bad, 0);
    chk("lock_issues", iss2, 3);
    chk("lock_dones", d2, 3);
    chk("lock_next", nxt, 4'b1000);
    i_req = '0;
    drain();

    // Hart 1 moves ptr to 2, then reset aborts hart 2
    rv = '{1, 1, 1'b0, 3'd0, 32'hA0, 32'h0,
           128'hA5, 1'b0, 4};
    run_vec(rv);
    cur_lat  = 6;
    cur_data = 128'hBAD;
    i_addr[64 +: 32] = 32'h6000_0000;
    i_req[2] = 1'b1;
    repeat (4) tick();
    chk("prerst_gnt", o_gnt, 4'b0100);
    RST_X = 1'b0;
    i_req = '0;
    tick();
    chk("mrst_gnt", o_gnt, 4'b0);
    chk("mrst_done", o_done, 4'b0);
    chk("mrst_memreq", w_mem_req, 1'b0);
    chk("mrst_rdata", o_rdata, 128'h0);
    chk("mrst_addr", w_data_addr, 32'h0);
    RST_X = 1'b1;
    dn = 0;
    repeat (8) begin
      tick();
      if (o_done != '0 || o_gnt != '0) dn++;
    end
    chk("mrst_quiet", dn, 0);
    i_req   = 4'b1010;
    cur_lat = 1;
    tick();
    chk("mrst_ptr0", o_gnt, 4'b0010);
    i_req = '0;
    drain();

    // Randomized run against the transaction model
    RST_X  = 1'b0;
    i_lock = '0;
    tick();
    RST_X = 1'b1;
    owner = -1; issue_at = -1; done_at = -1;
    idle_from = 0; mptr = 0; rd_at = -1;
    rd_exp = '0;
    for (int now = 0; now < 1500; now++) begin
      exp_g = (owner >= 0) ? (4'b0001 << owner) : 4'b0;
      chk("rnd_gnt", o_gnt, exp_g);
      chk("rnd_stall", o_stall, i_req & ~exp_g);
      chk("rnd_memreq", w_mem_req, (now == issue_at));
      chk("rnd_done", o_done,
          (now == done_at) ? exp_g : 4'b0);
      if (now == issue_at) begin
        chk("rnd_addr", w_data_addr, e_addr);
        chk("rnd_wdata", w_data_wdata, e_wdata);
        chk("rnd_we", w_data_we, e_we);
        chk("rnd_ctrl", w_data_ctrl, e_ctrl);
      end
      if (now == rd_at)
        chk("rnd_rdata", o_rdata, rd_exp);
      skip = -1;
      if (now == done_at) begin
        rd_at  = now + 1;
        rd_exp = e_rdata;
        if (i_lock[owner] && $urandom_range(0, 1) == 1) begin
          new_fields(owner);
          start_txn(owner, now + 1);
        end else begin
          i_req[owner]  = 1'b0;
          i_lock[owner] = 1'b0;
          skip      = owner;
          mptr      = (owner + 1) % N;
          owner     = -1;
          idle_from = now + 1;
        end
      end else if (owner >= 0 && now > issue_at &&
                   $urandom_range(0, 3) == 0) begin
        i_addr[32*owner +: 32]  = $urandom;
        i_wdata[32*owner +: 32] = $urandom;
      end
      for (int h = 0; h < N; h++) begin
        if (h != owner && h != skip && !i_req[h] &&
            $urandom_range(0, 2) == 0) begin
          new_fields(h);
          i_lock[h] = ($urandom_range(0, 3) == 0);
          i_req[h]  = 1'b1;
        end
      end
      if (owner < 0 && now >= idle_from && i_req != '0) begin
        owner = rr_pick(i_req, mptr);
        start_txn(owner, now + 1);
      end
      tick();
    end
    i_req  = '0;
    i_lock = '0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
